// File: rtl/evm_pkg.sv
// Shared definitions for the voting machine core.
// Holds the mode encodings, the press-detector state enum and two one-hot helpers.
// The helpers work on a 16-bit vector, which is the widest candidate count supported.
package evm_pkg;

    localparam int unsigned MAX_CAND = 16;

    localparam logic [1:0] MODE_RESULT = 2'b00;
    localparam logic [1:0] MODE_VOTE   = 2'b01;
    localparam logic [1:0] MODE_LOCKED = 2'b10;  // 2'b11 also decodes as locked

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        CAST,
        WAIT_REL,
        LOCKOUT
    } press_state_e;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [MAX_CAND-1:0] v);
        return (v != '0) && ((v & (v - 16'd1)) == '0);
    endfunction

    // Index of the set bit of a one-hot vector (highest set bit otherwise).
    function automatic logic [3:0] onehot_to_idx(input logic [MAX_CAND-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_CAND; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/evm_press_detect.sv
// Debounced press detector: turns a held button pattern into a single cast strobe.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   vote_en        high while the machine is in VOTE mode
//   button         synchronised candidate buttons
//   cast_c         high during the CAST cycle (combinational)
//   cast_idx_c     candidate index being cast (combinational)
//   invalid_press  one-cycle pulse when several buttons were held long enough
// Optional: define VOTE_LOCKOUT_EN to add a dead time after each cast vote.
module evm_press_detect
    import evm_pkg::*;
#(
    parameter int unsigned NUM_CAND       = 4,
    parameter int unsigned HOLD_CYCLES    = 3,
    parameter int unsigned LOCKOUT_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vote_en,
    input  logic [NUM_CAND-1:0] button,
    output logic                cast_c,
    output logic [3:0]          cast_idx_c,
    output logic                invalid_press
);

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > LOCKOUT_CYCLES) ? HOLD_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned HC_W    = $clog2(CNT_MAX + 1);

    press_state_e        state_q, state_d;
    logic [NUM_CAND-1:0] press_q, press_d;
    logic [HC_W-1:0]     hold_cnt_q, hold_d, hold_inc;
    logic                was_vote_q;
    logic                invalid_d;
`ifdef VOTE_LOCKOUT_EN
    logic                cast_done_q, cast_done_d;
`endif

    // State, sample and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            press_q       <= '0;
            hold_cnt_q    <= '0;
            was_vote_q    <= 1'b0;
            invalid_press <= 1'b0;
`ifdef VOTE_LOCKOUT_EN
            cast_done_q   <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            press_q       <= press_d;
            hold_cnt_q    <= hold_d;
            was_vote_q    <= vote_en;
            invalid_press <= invalid_d;
`ifdef VOTE_LOCKOUT_EN
            cast_done_q   <= cast_done_d;
`endif
        end
    end

    // Next-state logic; the hold counter doubles as the lockout timer.
    always_comb begin
        state_d   = state_q;
        press_d   = press_q;
        hold_d    = hold_cnt_q;
        invalid_d = 1'b0;
        hold_inc  = hold_cnt_q + HC_W'(1);
`ifdef VOTE_LOCKOUT_EN
        cast_done_d = cast_done_q;
`endif
        if (!vote_en) begin
            state_d = IDLE;
            hold_d  = '0;
`ifdef VOTE_LOCKOUT_EN
            cast_done_d = 1'b0;
`endif
        end else if (!was_vote_q) begin
            // First VOTE cycle: a button already held must be released first.
            state_d = (button != '0) ? WAIT_REL : IDLE;
            hold_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (button != '0) begin
                        press_d = button;
                        hold_d  = HC_W'(1);
                        state_d = ARM;
                        if (HOLD_CYCLES == 1) begin
                            state_d   = is_onehot(MAX_CAND'(button)) ? CAST : WAIT_REL;
                            invalid_d = !is_onehot(MAX_CAND'(button));
                        end
                    end
                end
                ARM: begin
                    if (button == '0) begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end else if (button != press_q) begin
                        press_d = button;
                        hold_d  = HC_W'(1);
                    end else begin
                        hold_d = hold_inc;
                        if (hold_inc == HC_W'(HOLD_CYCLES)) begin
                            if (is_onehot(MAX_CAND'(press_q))) begin
                                state_d = CAST;
                            end else begin
                                state_d   = WAIT_REL;
                                invalid_d = 1'b1;
                            end
                        end
                    end
                end
                CAST: begin
                    state_d = WAIT_REL;
                    hold_d  = '0;
`ifdef VOTE_LOCKOUT_EN
                    cast_done_d = 1'b1;
`endif
                end
                WAIT_REL: begin
                    if (button == '0) begin
                        state_d = IDLE;
                        hold_d  = '0;
`ifdef VOTE_LOCKOUT_EN
                        if (cast_done_q) state_d = LOCKOUT;
                        cast_done_d = 1'b0;
`endif
                    end
                end
                LOCKOUT: begin
`ifdef VOTE_LOCKOUT_EN
                    hold_d = hold_inc;
                    if (hold_inc == HC_W'(LOCKOUT_CYCLES)) begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end
`else
                    state_d = IDLE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign cast_c     = (state_q == CAST) && vote_en;
    assign cast_idx_c = onehot_to_idx(MAX_CAND'(press_q));

endmodule

// File: rtl/evm_tally_core.sv
// Voting machine core: saturating per-candidate tally, total, LED ack and winner/tie readout.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   mode           00 RESULT, 01 VOTE, 1x LOCKED
//   button         synchronised candidate buttons
//   led            one-hot vote acknowledge, lit LED_CYCLES cycles per cast
//   votes          packed counters, candidate i at [i*CNT_W +: CNT_W]
//   total          sum of all votes
//   winner, tie    registered result comparator outputs (updated in RESULT mode)
//   results_valid  high in RESULT mode once winner/tie have settled
//   invalid_press  pulse when more than one button was held long enough
// Optional: define VOTE_LOCKOUT_EN to add a post-vote lockout in the press detector.
module evm_tally_core
    import evm_pkg::*;
#(
    parameter int unsigned NUM_CAND       = 4,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned HOLD_CYCLES    = 3,
    parameter int unsigned LED_CYCLES     = 4,
    parameter int unsigned LOCKOUT_CYCLES = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [1:0]                          mode,
    input  logic [NUM_CAND-1:0]                 button,
    output logic [NUM_CAND-1:0]                 led,
    output logic [NUM_CAND*CNT_W-1:0]           votes,
    output logic [CNT_W+$clog2(NUM_CAND)-1:0]   total,
    output logic [$clog2(NUM_CAND)-1:0]         winner,
    output logic                                tie,
    output logic                                results_valid,
    output logic                                invalid_press
);

    localparam int unsigned IDX_W = $clog2(NUM_CAND);
    localparam int unsigned TOT_W = CNT_W + IDX_W;
    localparam int unsigned LED_W = $clog2(LED_CYCLES + 1);

    logic                vote_en, result_en;
    logic                cast_c;
    logic [3:0]          cast_idx_c;
    logic [CNT_W-1:0]    cnt_q [NUM_CAND];
    logic [NUM_CAND-1:0] bump_c;
    logic [LED_W-1:0]    led_tmr_q;
    logic [1:0]          res_age_q;
    logic [CNT_W-1:0]    best_c;
    logic [IDX_W-1:0]    win_c;
    logic                tie_c, seen_c;

    assign vote_en   = (mode == MODE_VOTE);
    assign result_en = (mode == MODE_RESULT);

    evm_press_detect #(
        .NUM_CAND       (NUM_CAND),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) u_press (
        .clk           (clk),
        .rst_n         (rst_n),
        .vote_en       (vote_en),
        .button        (button),
        .cast_c        (cast_c),
        .cast_idx_c    (cast_idx_c),
        .invalid_press (invalid_press)
    );

    // Per-candidate increment enables; a full counter blocks its own and the total's update.
    always_comb begin
        bump_c = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            bump_c[i] = cast_c && (cast_idx_c == 4'(i)) && (cnt_q[i] != '1);
        end
    end

    // Vote counters and total.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CAND; i++) cnt_q[i] <= '0;
            total <= '0;
        end else begin
            for (int i = 0; i < NUM_CAND; i++) begin
                if (bump_c[i]) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
            if (bump_c != '0) total <= total + TOT_W'(1);
        end
    end

    for (genvar g = 0; g < NUM_CAND; g++) begin : g_votes
        assign votes[g*CNT_W +: CNT_W] = cnt_q[g];
    end

    // LED acknowledge timer; frozen while locked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led       <= '0;
            led_tmr_q <= '0;
        end else if (cast_c) begin
            led       <= NUM_CAND'(1) << cast_idx_c;
            led_tmr_q <= LED_W'(LED_CYCLES - 1);
        end else if (!mode[1]) begin
            if (led_tmr_q != '0) led_tmr_q <= led_tmr_q - LED_W'(1);
            else                 led       <= '0;
        end
    end

    // Max search: strict compare keeps the lowest index on equal counts.
    always_comb begin
        best_c = cnt_q[0];
        win_c  = '0;
        for (int i = 1; i < NUM_CAND; i++) begin
            if (cnt_q[i] > best_c) begin
                best_c = cnt_q[i];
                win_c  = IDX_W'(i);
            end
        end
        tie_c  = 1'b0;
        seen_c = 1'b0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (cnt_q[i] == best_c) begin
                if (seen_c) tie_c = 1'b1;
                seen_c = 1'b1;
            end
        end
        tie_c = tie_c && (total != '0);
    end

    // Result registers: refreshed only in RESULT mode, valid from the second cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            winner        <= '0;
            tie           <= 1'b0;
            results_valid <= 1'b0;
            res_age_q     <= '0;
        end else if (result_en) begin
            winner        <= win_c;
            tie           <= tie_c;
            results_valid <= (res_age_q != 2'd0);
            if (res_age_q != 2'd2) res_age_q <= res_age_q + 2'd1;
        end else begin
            results_valid <= 1'b0;
            res_age_q     <= '0;
        end
    end

endmodule

// File: tb/tb_evm_tally_core.sv
// Self-checking bench for evm_tally_core (4 candidates, 4-bit counters).
module tb_evm_tally_core;

    localparam int unsigned NUM_CAND = 4;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned TOT_W    = 6;
    localparam int unsigned LOCKOUT  = 8;
`ifdef VOTE_LOCKOUT_EN
    localparam int REL = LOCKOUT + 3;
`else
    localparam int REL = 2;
`endif

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [1:0]                mode;
    logic [NUM_CAND-1:0]       button;
    logic [NUM_CAND-1:0]       led;
    logic [NUM_CAND*CNT_W-1:0] votes;
    logic [TOT_W-1:0]          total;
    logic [1:0]                winner;
    logic                      tie, results_valid, invalid_press;

    typedef struct {
        int               cand;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   model_votes[NUM_CAND];
    int   model_total;
    int   errors = 0;
    int   checks = 0;

    evm_tally_core #(
        .NUM_CAND       (NUM_CAND),
        .CNT_W          (CNT_W),
        .HOLD_CYCLES    (3),
        .LED_CYCLES     (4),
        .LOCKOUT_CYCLES (LOCKOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mode          (mode),
        .button        (button),
        .led           (led),
        .votes         (votes),
        .total         (total),
        .winner        (winner),
        .tie           (tie),
        .results_valid (results_valid),
        .invalid_press (invalid_press)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NUM_CAND*CNT_W-1:0] pack_model();
        logic [NUM_CAND*CNT_W-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_CAND; i++) p[i*CNT_W +: CNT_W] = CNT_W'(model_votes[i]);
        return p;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NUM_CAND; i++) model_votes[i] = 0;
        model_total = 0;
    endtask

    // Record the expected cast, then drive a single-button press.
    task automatic push_vote(input int c);
        exp_t e;
        if (model_votes[c] < 15) begin
            model_votes[c]++;
            model_total++;
        end
        e.cand = c;
        e.cnt  = CNT_W'(model_votes[c]);
        exp_q.push_back(e);
    endtask

    task automatic do_vote(input int c);
        push_vote(c);
        button = NUM_CAND'(1 << c);
        repeat (4) step();
        button = '0;
        repeat (REL) step();
    endtask

    // Scoreboard monitor: every LED rising edge is a cast; match it to the oldest expectation.
    always @(posedge clk) begin : mon
        logic [NUM_CAND-1:0] led_prev;
        logic [NUM_CAND-1:0] exp_led;
        exp_t e;
        #1;
        if (rst_n === 1'b1 && led !== '0 && led_prev === '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_cast led=%b votes=%h", led, votes);
            end else begin
                e = exp_q.pop_front();
                exp_led = NUM_CAND'(1 << e.cand);
                if (led !== exp_led || votes[e.cand*CNT_W +: CNT_W] !== e.cnt) begin
                    errors++;
                    $display("FAIL cast_cand%0d led=%b cnt=%0d expected led=%b cnt=%0d",
                             e.cand, led, votes[e.cand*CNT_W +: CNT_W], exp_led, e.cnt);
                end
            end
        end
        led_prev = led;
    end

    task automatic test_reset();
        rst_n = 1'b0; mode = 2'b01; button = '0;
        clear_model();
        repeat (2) step();
        checks++;
        if ({led, votes, total} !== '0) begin
            errors++; $display("FAIL reset_counts led=%b votes=%h total=%0d expected 0", led, votes, total);
        end
        checks++;
        if ({winner, tie, results_valid, invalid_press} !== '0) begin
            errors++; $display("FAIL reset_flags w=%0d t=%b rv=%b inv=%b expected 0",
                               winner, tie, results_valid, invalid_press);
        end
        rst_n = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_basic();
        int led_hi = 0;
        for (int v = 0; v < 2; v++) begin
            push_vote(0);
            button = 4'b0001;
            for (int k = 1; k <= 4; k++) begin
                step();
                if (led[0]) led_hi++;
                if (k == 3) begin
                    checks++;
                    if (votes[3:0] !== 4'(v)) begin
                        errors++; $display("FAIL early_vote v%0d got=%0d expected %0d", v, votes[3:0], v);
                    end
                end
                if (k == 4) begin
                    checks++;
                    if (votes[3:0] !== 4'(v + 1)) begin
                        errors++; $display("FAIL latency v%0d got=%0d expected %0d", v, votes[3:0], v + 1);
                    end
                end
            end
            button = '0;
            for (int k = 0; k < REL; k++) begin
                step();
                if (led[0]) led_hi++;
            end
        end
        repeat (6) begin
            step();
            if (led[0]) led_hi++;
        end
        checks++;
        if (led_hi != 8) begin
            errors++; $display("FAIL led_duration got=%0d expected 8", led_hi);
        end
        checks++;
        if (total !== 6'd2) begin
            errors++; $display("FAIL basic_total got=%0d expected 2", total);
        end
    endtask

    task automatic test_long_hold();
        push_vote(1);
        button = 4'b0010;
        repeat (20) step();
        button = '0;
        repeat (REL) step();
        checks++;
        if (votes !== pack_model() || total !== TOT_W'(model_total)) begin
            errors++; $display("FAIL long_hold votes=%h total=%0d expected %h/%0d",
                               votes, total, pack_model(), model_total);
        end
    endtask

    task automatic test_invalid();
        int pulses = 0;
        button = 4'b0110;
        repeat (5) begin
            step();
            if (invalid_press) pulses++;
        end
        button = '0;
        repeat (REL) begin
            step();
            if (invalid_press) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++; $display("FAIL invalid_pulses got=%0d expected 1", pulses);
        end
        checks++;
        if (votes !== pack_model() || total !== TOT_W'(model_total)) begin
            errors++; $display("FAIL invalid_counts votes=%h total=%0d expected %h/%0d",
                               votes, total, pack_model(), model_total);
        end
    endtask

    task automatic test_results();
        int plan[NUM_CAND] = '{4, 2, 7, 3};
        rst_n = 1'b0;
        step();
        clear_model();
        rst_n = 1'b1;
        repeat (2) step();
        for (int c = 0; c < NUM_CAND; c++) begin
            for (int n = 0; n < plan[c]; n++) do_vote(c);
        end
        checks++;
        if (votes !== pack_model() || total !== 6'd16) begin
            errors++; $display("FAIL tally_4273 votes=%h total=%0d expected %h/16", votes, total, pack_model());
        end
        mode = 2'b00;
        step();
        checks++;
        if (winner !== 2'd2 || tie !== 1'b0 || results_valid !== 1'b0) begin
            errors++; $display("FAIL result_c1 w=%0d t=%b rv=%b expected 2/0/0", winner, tie, results_valid);
        end
        step();
        checks++;
        if (results_valid !== 1'b1) begin
            errors++; $display("FAIL result_valid got=%b expected 1", results_valid);
        end
        mode = 2'b01;
        step();
        checks++;
        if (results_valid !== 1'b0) begin
            errors++; $display("FAIL valid_exit got=%b expected 0", results_valid);
        end
        repeat (4) do_vote(3);
        mode = 2'b00;
        repeat (2) step();
        checks++;
        if (winner !== 2'd2 || tie !== 1'b1 || results_valid !== 1'b1) begin
            errors++; $display("FAIL result_tie w=%0d t=%b rv=%b expected 2/1/1", winner, tie, results_valid);
        end
        mode = 2'b10;
        step();
        checks++;
        if (winner !== 2'd2 || tie !== 1'b1 || results_valid !== 1'b0) begin
            errors++; $display("FAIL locked_frozen w=%0d t=%b rv=%b expected 2/1/0", winner, tie, results_valid);
        end
    endtask

    task automatic test_abort();
        mode = 2'b01;
        repeat (2) step();
        button = 4'b0001;
        repeat (2) step();
        mode = 2'b10;
        step();
        button = '0;
        step();
        mode = 2'b01;
        repeat (3) step();
        checks++;
        if (votes !== pack_model() || total !== TOT_W'(model_total)) begin
            errors++; $display("FAIL abort_counts votes=%h total=%0d expected %h/%0d",
                               votes, total, pack_model(), model_total);
        end
        // Button held across re-entry to VOTE must not vote.
        mode = 2'b10;
        step();
        button = 4'b0001;
        step();
        mode = 2'b01;
        repeat (10) step();
        button = '0;
        repeat (REL) step();
        checks++;
        if (total !== TOT_W'(model_total)) begin
            errors++; $display("FAIL reentry_hold total=%0d expected %0d", total, model_total);
        end
        // Asynchronous reset in the middle of ARM.
        button = 4'b0001;
        repeat (2) step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({led, votes, total, winner, tie, results_valid, invalid_press} !== '0) begin
            errors++; $display("FAIL async_reset led=%b votes=%h total=%0d w=%0d t=%b expected 0",
                               led, votes, total, winner, tie);
        end
        button = '0;
        clear_model();
        step();
        rst_n = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_saturation();
        repeat (15) do_vote(0);
        checks++;
        if (votes[3:0] !== 4'd15 || total !== 6'd15) begin
            errors++; $display("FAIL sat_fill cnt=%0d total=%0d expected 15/15", votes[3:0], total);
        end
        do_vote(0);
        checks++;
        if (votes[3:0] !== 4'd15 || total !== 6'd15) begin
            errors++; $display("FAIL sat_hold cnt=%0d total=%0d expected 15/15", votes[3:0], total);
        end
    endtask

`ifdef VOTE_LOCKOUT_EN
    task automatic test_lockout();
        push_vote(1);
        button = 4'b0010;
        repeat (4) step();
        button = '0;
        step();
        button = 4'b0010;
        repeat (4) step();
        button = '0;
        repeat (LOCKOUT + 2) step();
        checks++;
        if (votes !== pack_model() || total !== TOT_W'(model_total)) begin
            errors++; $display("FAIL lockout votes=%h total=%0d expected %h/%0d",
                               votes, total, pack_model(), model_total);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_long_hold();
        test_invalid();
        test_results();
        test_abort();
        test_saturation();
`ifdef VOTE_LOCKOUT_EN
        test_lockout();
`endif
        repeat (6) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL missing_casts pending=%0d expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

endmodule
